// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : morse_decoder
//  Purpose  : Morse key front-end. Synchronises and debounces a raw key,
//             times press/release intervals, classifies presses as dot or
//             dash, and decodes completed letters to ASCII. Emits one-cycle
//             char_valid pulses (letters and word spaces) and a one-cycle
//             clear pulse on a long hold.
//  Ports    : clk        in   1  clock (1 MHz nominal)
//             rst        in   1  asynchronous active-high reset
//             key        in   1  raw key, active-high, asynchronous to clk
//             char_out   out  8  decoded ASCII, held until next emission
//             char_valid out  1  one-cycle pulse, char_out valid this cycle
//             clear      out  1  one-cycle display clear request
//             key_db     out  1  debounced key level
//  Revision : 1.0  initial release
// ============================================================================
module morse_decoder #(
  parameter int DEBOUNCE_CYCLES   = 5000,
  parameter int DASH_MIN_CYCLES   = 200000,
  parameter int LETTER_GAP_CYCLES = 600000,
  parameter int WORD_GAP_CYCLES   = 1400000,
  parameter int CLEAR_CYCLES      = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       clear,
  output logic       key_db
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DB_W-1:0] c_db_last    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [20:0]     c_dash_min   = 21'(DASH_MIN_CYCLES);
  localparam logic [20:0]     c_letter_gap = 21'(LETTER_GAP_CYCLES);
  localparam logic [20:0]     c_word_gap   = 21'(WORD_GAP_CYCLES);
  localparam logic [20:0]     c_clear      = 21'(CLEAR_CYCLES);
  localparam logic [7:0]      c_space      = 8'h20;
  localparam logic [7:0]      c_unknown    = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS     = 2'd1,
    ST_GAP       = 2'd2,
    ST_WORD_WAIT = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            key_db_q, key_db_d;
  logic [20:0]     dur_q, dur_d;
  state_t          state_q, state_d;
  logic [4:0]      sym_bits_q, sym_bits_d;
  logic [2:0]      sym_len_q, sym_len_d;
  logic            overflow_q, overflow_d;
  logic            clr_hold_q, clr_hold_d;
  logic [7:0]      char_out_q, char_out_d;
  logic            char_valid_q, char_valid_d;
  logic            clear_q, clear_d;

  logic            db_rise;
  logic            db_fall;
  logic [20:0]     dur_inc;
  logic            clear_hit;
  logic            elem_dash;

  // --------------------------------------------------------------------------
  // Decode table. Elements enter at bit 0, so the first element of an
  // n-element letter sits at bit n-1 (dot=0, dash=1).
  // --------------------------------------------------------------------------
  function automatic logic [7:0] decode(input logic [2:0] len,
                                        input logic [4:0] bits,
                                        input logic       ovf);
    logic [7:0] ch;
    ch = c_unknown;
    if (!ovf) begin
      case (len)
        3'd1: begin
          case (bits[0])
            1'b0:    ch = 8'h45; // E
            default: ch = 8'h54; // T
          endcase
        end
        3'd2: begin
          case (bits[1:0])
            2'b00:   ch = 8'h49; // I
            2'b01:   ch = 8'h41; // A
            2'b10:   ch = 8'h4E; // N
            default: ch = 8'h4D; // M
          endcase
        end
        3'd3: begin
          case (bits[2:0])
            3'b000:  ch = 8'h53; // S
            3'b001:  ch = 8'h55; // U
            3'b010:  ch = 8'h52; // R
            3'b011:  ch = 8'h57; // W
            3'b100:  ch = 8'h44; // D
            3'b101:  ch = 8'h4B; // K
            3'b110:  ch = 8'h47; // G
            default: ch = 8'h4F; // O
          endcase
        end
        3'd4: begin
          case (bits[3:0])
            4'b0000: ch = 8'h48; // H
            4'b0001: ch = 8'h56; // V
            4'b0010: ch = 8'h46; // F
            4'b0100: ch = 8'h4C; // L
            4'b0110: ch = 8'h50; // P
            4'b0111: ch = 8'h4A; // J
            4'b1000: ch = 8'h42; // B
            4'b1001: ch = 8'h58; // X
            4'b1010: ch = 8'h43; // C
            4'b1011: ch = 8'h59; // Y
            4'b1100: ch = 8'h5A; // Z
            4'b1101: ch = 8'h51; // Q
            default: ch = c_unknown;
          endcase
        end
        3'd5: begin
          case (bits)
            5'b11111: ch = 8'h30; // 0
            5'b01111: ch = 8'h31; // 1
            5'b00111: ch = 8'h32; // 2
            5'b00011: ch = 8'h33; // 3
            5'b00001: ch = 8'h34; // 4
            5'b00000: ch = 8'h35; // 5
            5'b10000: ch = 8'h36; // 6
            5'b11000: ch = 8'h37; // 7
            5'b11100: ch = 8'h38; // 8
            5'b11110: ch = 8'h39; // 9
            default:  ch = c_unknown;
          endcase
        end
        default: ch = c_unknown;
      endcase
    end
    return ch;
  endfunction

  // --------------------------------------------------------------------------
  // Synchroniser and debounce
  // --------------------------------------------------------------------------
  always_comb begin
    sync1_d  = key;
    sync2_d  = sync1_q;
    db_cnt_d = '0;
    key_db_d = key_db_q;
    if (sync2_q != key_db_q) begin
      if (db_cnt_q == c_db_last) begin
        key_db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Edges are taken on the update that flips key_db, so the FSM moves in
  // the same cycle key_db changes and dur reads 0 in the first cycle of
  // the new level.
  assign db_rise = key_db_d & ~key_db_q;
  assign db_fall = ~key_db_d & key_db_q;

  assign dur_inc = (dur_q == '1) ? dur_q : dur_q + 21'd1;
  assign dur_d   = (db_rise || db_fall) ? '0 : dur_inc;

  // Thresholds compare against dur_inc so an event lands in the cycle in
  // which dur_q equals the threshold, and the clear threshold still sees
  // its count on an edge update (where dur_d would already be cleared).
  assign clear_hit = (state_q == ST_PRESS) && !clr_hold_q && (dur_inc == c_clear);
  assign elem_dash = (dur_inc >= c_dash_min);

  // --------------------------------------------------------------------------
  // FSM next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    sym_bits_d   = sym_bits_q;
    sym_len_d    = sym_len_q;
    overflow_d   = overflow_q;
    clr_hold_d   = clr_hold_q;
    char_out_d   = char_out_q;
    char_valid_d = 1'b0;
    clear_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (db_rise) begin
          state_d    = ST_PRESS;
          clr_hold_d = 1'b0;
        end
      end

      ST_PRESS: begin
        if (clear_hit) begin
          clear_d    = 1'b1;
          sym_bits_d = '0;
          sym_len_d  = '0;
          overflow_d = 1'b0;
          clr_hold_d = 1'b1;
        end
        if (db_fall) begin
          if (clr_hold_q || clear_hit) begin
            state_d    = ST_IDLE;
            clr_hold_d = 1'b0;
          end else begin
            if (sym_len_q == 3'd5) begin
              overflow_d = 1'b1;
            end else begin
              sym_bits_d = {sym_bits_q[3:0], elem_dash};
              sym_len_d  = sym_len_q + 3'd1;
            end
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (db_rise) begin
          state_d = ST_PRESS;
        end else if (dur_inc == c_letter_gap) begin
          char_out_d   = decode(sym_len_q, sym_bits_q, overflow_q);
          char_valid_d = 1'b1;
          sym_bits_d   = '0;
          sym_len_d    = '0;
          overflow_d   = 1'b0;
          state_d      = ST_WORD_WAIT;
        end
      end

      ST_WORD_WAIT: begin
        if (db_rise) begin
          state_d = ST_PRESS;
        end else if (dur_inc == c_word_gap) begin
          char_out_d   = c_space;
          char_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_cnt_q     <= '0;
      key_db_q     <= 1'b0;
      dur_q        <= '0;
      state_q      <= ST_IDLE;
      sym_bits_q   <= '0;
      sym_len_q    <= '0;
      overflow_q   <= 1'b0;
      clr_hold_q   <= 1'b0;
      char_out_q   <= c_space;
      char_valid_q <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_cnt_q     <= db_cnt_d;
      key_db_q     <= key_db_d;
      dur_q        <= dur_d;
      state_q      <= state_d;
      sym_bits_q   <= sym_bits_d;
      sym_len_q    <= sym_len_d;
      overflow_q   <= overflow_d;
      clr_hold_q   <= clr_hold_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      clear_q      <= clear_d;
    end
  end

  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign clear      = clear_q;
  assign key_db     = key_db_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_decoder
//  Purpose  : Directed self-checking bench for morse_decoder with short
//             timing parameters (debounce 4, dash 20, letter gap 40,
//             word gap 100, clear 200).
//  Revision : 1.0  initial release
// ============================================================================
module tb_morse_decoder;

  logic       clk;
  logic       rst;
  logic       key;
  logic [7:0] char_out;
  logic       char_valid;
  logic       clear;
  logic       key_db;

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor state, written only by the negedge monitor
  int         ncyc     = 0;
  int         rise_t   = 0;
  int         fall_t   = 0;
  int         rise_cnt = 0;
  int         overlap  = 0;
  logic       prev_db  = 1'b0;
  logic [7:0] ev_ch[$];
  int         ev_t[$];
  int         clr_t[$];

  morse_decoder #(
    .DEBOUNCE_CYCLES   (4),
    .DASH_MIN_CYCLES   (20),
    .LETTER_GAP_CYCLES (40),
    .WORD_GAP_CYCLES   (100),
    .CLEAR_CYCLES      (200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .char_out   (char_out),
    .char_valid (char_valid),
    .clear      (clear),
    .key_db     (key_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (key_db && !prev_db) begin
      rise_t   <= ncyc;
      rise_cnt <= rise_cnt + 1;
    end
    if (!key_db && prev_db) fall_t <= ncyc;
    prev_db <= key_db;
    if (char_valid) begin
      ev_ch.push_back(char_out);
      ev_t.push_back(ncyc);
    end
    if (clear) clr_t.push_back(ncyc);
    if (char_valid && clear) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_key(input logic lvl, input int n);
    key = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dot();  hold_key(1'b1, 10); endtask
  task automatic dash(); hold_key(1'b1, 30); endtask
  task automatic gap();  hold_key(1'b0, 10); endtask
  task automatic idle(); hold_key(1'b0, 150); endtask

  int base;
  int cbase;
  int rbase;

  initial begin
    key = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_char_out",   char_out,   8'h20);
    chk("reset_char_valid", char_valid, 0);
    chk("reset_clear",      clear,      0);
    chk("reset_key_db",     key_db,     0);
    rst = 1'b0;
    hold_key(1'b0, 5);

    // Single dot with key_db latency check
    base = ev_ch.size();
    key = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("latency_before", key_db, 0);
    @(posedge clk);
    #1;
    chk("latency_at", key_db, 1);
    hold_key(1'b1, 4);
    hold_key(1'b0, 200);
    chk("dot_count", ev_ch.size() - base, 2);
    chk("dot_char",  ev_ch[base],     8'h45);
    chk("dot_space", ev_ch[base + 1], 8'h20);
    chk("dot_letter_time", ev_t[base] - fall_t, 40);
    chk("dot_space_time",  ev_t[base + 1] - fall_t, 100);

    // A: dot dash
    base = ev_ch.size();
    dot(); gap(); dash(); idle();
    chk("a_count", ev_ch.size() - base, 2);
    chk("a_char",  ev_ch[base],     8'h41);
    chk("a_space", ev_ch[base + 1], 8'h20);

    // B: dash dot dot dot
    base = ev_ch.size();
    dash(); gap(); dot(); gap(); dot(); gap(); dot(); idle();
    chk("b_count", ev_ch.size() - base, 2);
    chk("b_char",  ev_ch[base],     8'h42);
    chk("b_space", ev_ch[base + 1], 8'h20);

    // 0: five dashes
    base = ev_ch.size();
    dash(); gap(); dash(); gap(); dash(); gap(); dash(); gap(); dash(); idle();
    chk("zero_count", ev_ch.size() - base, 2);
    chk("zero_char",  ev_ch[base], 8'h30);

    // Six dots overflow
    base = ev_ch.size();
    dot(); gap(); dot(); gap(); dot(); gap(); dot(); gap(); dot(); gap(); dot(); idle();
    chk("ovf_count", ev_ch.size() - base, 2);
    chk("ovf_char",  ev_ch[base], 8'h3F);

    // E, 50-cycle gap, T: no space between
    base = ev_ch.size();
    dot(); hold_key(1'b0, 50); dash(); idle();
    chk("et_count", ev_ch.size() - base, 3);
    chk("et_e",     ev_ch[base],     8'h45);
    chk("et_t",     ev_ch[base + 1], 8'h54);
    chk("et_space", ev_ch[base + 2], 8'h20);

    // Press at gap 39 continues the letter: I
    base = ev_ch.size();
    dot(); hold_key(1'b0, 39); dot(); idle();
    chk("i_count", ev_ch.size() - base, 2);
    chk("i_char",  ev_ch[base], 8'h49);

    // Glitch rejection
    base  = ev_ch.size();
    rbase = rise_cnt;
    for (int g = 0; g < 3; g++) begin
      hold_key(1'b1, 3);
      hold_key(1'b0, 10);
    end
    idle();
    chk("glitch_rises", rise_cnt - rbase, 0);
    chk("glitch_chars", ev_ch.size() - base, 0);

    // Dash/dot boundary
    base = ev_ch.size();
    hold_key(1'b1, 21); idle();
    chk("p21_char", ev_ch[base], 8'h54);
    base = ev_ch.size();
    hold_key(1'b1, 19); idle();
    chk("p19_char", ev_ch[base], 8'h45);

    // Long-press clear discards pending dot
    base  = ev_ch.size();
    cbase = clr_t.size();
    dot(); gap(); hold_key(1'b1, 250); idle();
    chk("clear_count", clr_t.size() - cbase, 1);
    chk("clear_time",  clr_t[cbase] - rise_t, 200);
    chk("clear_chars", ev_ch.size() - base, 0);
    base = ev_ch.size();
    dot(); idle();
    chk("post_clear_count", ev_ch.size() - base, 2);
    chk("post_clear_char",  ev_ch[base], 8'h45);

    // Reset in GAP with A pending (after an E left char_out at 0x45)
    base = ev_ch.size();
    dot(); hold_key(1'b0, 60);
    dot(); gap(); dash(); hold_key(1'b0, 20);
    chk("pre_rst_char_out", char_out, 8'h45);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_char_out",   char_out,   8'h20);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_clear",      clear,      0);
    chk("rst_key_db",     key_db,     0);
    rst = 1'b0;
    hold_key(1'b0, 200);
    chk("rst_events", ev_ch.size() - base, 1);
    chk("rst_first",  ev_ch[base], 8'h45);

    chk("pulse_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
